// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns stage: one 32-bit column per clock, result held
// until the next round stage accepts it; bypass passes the state through unchanged.
module mix_columns_seq #(
    parameter int unsigned NB   = 128,
    parameter int unsigned BYTE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NB-1:0] in_data,
    input  logic          in_bypass,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NB-1:0] out_data
);

    localparam int unsigned COLW = 4 * BYTE;
    localparam int unsigned NCOL = NB / COLW;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [NB-1:0]   data_q, data_d;
    logic            in_ready_d;
    logic            out_valid_d;
    logic [NB-1:0]   out_data_d;

    // GF(2^8) multiply by 2 with the AES reduction polynomial
    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
        return {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? BYTE'(8'h1b) : BYTE'(0));
    endfunction

    function automatic logic [COLW-1:0] mix_col(input logic [COLW-1:0] col);
        logic [BYTE-1:0] a0, a1, a2, a3;
        logic [BYTE-1:0] d0, d1, d2, d3;
        logic [BYTE-1:0] b0, b1, b2, b3;
        a0 = col[0*BYTE +: BYTE];
        a1 = col[1*BYTE +: BYTE];
        a2 = col[2*BYTE +: BYTE];
        a3 = col[3*BYTE +: BYTE];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        b0 = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
        b3 = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
        return {b3, b2, b1, b0};
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            data_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            data_q    <= data_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

    // Next-state, column processing and output register inputs
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        data_d      = data_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;

        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    data_d     = in_data;
                    in_ready_d = 1'b0;
                    if (in_bypass) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                    end else begin
                        state_d = BUSY;
                        col_d   = '0;
                    end
                end
            end
            BUSY: begin
                for (int unsigned c = 0; c < NCOL; c++) begin
                    if (col_q == CW'(c)) begin
                        data_d[c*COLW +: COLW] = mix_col(data_q[c*COLW +: COLW]);
                    end
                end
                col_d = col_q + CW'(1);
                if (col_q == CW'(NCOL - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = data_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule
